mem_requester: RTL
==================

MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 SHALL have parameter cache_block, default 512, meaning block width in bits.
REQ-002 SHALL have parameter main_mem_size, default 512*1024*1024*8, meaning memory size in bits; ADDR_W = log(main_mem_size/cache_block) (23 at defaults), computed with FUNCTIONS::log.
REQ-003 SHALL have parameter MEM_LATENCY, default 2, range 1..15, meaning cycles from strobe rise until memory data_out is valid.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port req_valid  input  1  cache presents a command.
REQ-007 SHALL have port req_ready  output  1  requester idle and accepting.
REQ-008 SHALL have port req_wb  input  1  command includes a block write-back.
REQ-009 SHALL have port req_rd  input  1  command includes a block fill.
REQ-010 SHALL have port wb_addr  input  ADDR_W  write-back block address.
REQ-011 SHALL have port wb_data  input  cache_block  write-back block data.
REQ-012 SHALL have port rd_addr  input  ADDR_W  fill block address.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port fill_data  output  cache_block  captured fill block, valid when done=1 and the command had req_rd=1.
REQ-015 SHALL have port mem_read  output  1  read strobe to main memory.
REQ-016 SHALL have port mem_write  output  1  write strobe to main memory.
REQ-017 SHALL have port mem_addr  output  ADDR_W  block address to main memory.
REQ-018 SHALL have port mem_wdata  output  cache_block  write data to main memory.
REQ-019 SHALL have port mem_rdata  input  cache_block  main memory data_out.

Function
REQ-020 SHALL implement states IDLE, WB_STB, WB_WAIT, RD_STB, RD_WAIT, DONE.
REQ-021 SHALL accept a command only on a cycle with req_valid=1 and req_ready=1; req_ready SHALL be 1 only in IDLE.
REQ-022 SHALL latch req_wb, req_rd, wb_addr, wb_data and rd_addr on acceptance; later input changes SHALL have no effect until the next acceptance.
REQ-023 On acceptance, SHALL go to WB_STB if req_wb=1, else RD_STB if req_rd=1, else DONE.
REQ-024 In WB_STB, SHALL assert mem_write=1 for exactly one cycle, with mem_addr=latched wb_addr and mem_wdata=latched wb_data, then go to WB_WAIT.
REQ-025 In WB_WAIT, SHALL hold mem_addr and mem_wdata for MEM_LATENCY cycles with mem_write=0, then go to RD_STB if latched req_rd=1, else DONE.
REQ-026 In RD_STB, SHALL assert mem_read=1 for exactly one cycle with mem_addr=latched rd_addr, then go to RD_WAIT.
REQ-027 In RD_WAIT, SHALL hold mem_addr for MEM_LATENCY cycles, then capture mem_rdata into fill_data on the last RD_WAIT clock edge and go to DONE.
REQ-028 In DONE, SHALL assert done=1 for one cycle, then return to IDLE.
REQ-029 mem_read and mem_write SHALL never both be 1, and each SHALL be 0 for at least MEM_LATENCY cycles between consecutive strobes, so every access produces a fresh rising edge of read|write.
REQ-030 The latency counter SHALL be 4 bits, SHALL load MEM_LATENCY-1 on entry to a WAIT state, and SHALL leave the WAIT state on the cycle it reaches 0; it SHALL NOT wrap.
REQ-031 A command with req_wb=0 and req_rd=0 SHALL produce done exactly 2 cycles after acceptance, with no strobes.
REQ-032 fill_data SHALL hold its value until the next capture; a write-back-only command SHALL NOT modify fill_data.
REQ-033 Acceptance-to-done latency SHALL be (wb ? 1+MEM_LATENCY : 0) + (rd ? 1+MEM_LATENCY : 0) + 1 cycles.

Reset
REQ-034 While reset_n=0 at a clock edge, SHALL set state=IDLE, mem_read=0, mem_write=0, done=0, mem_addr=0, mem_wdata=0, fill_data=0, counter=0; req_ready SHALL read 1 after reset release.
REQ-035 Reset asserted mid-command SHALL abandon the command with no done pulse and no further strobes; a strobe in progress SHALL drop on the reset edge.

Verification
REQ-036 Bench SHALL drive rd-only, rd_addr=0x000010, memory preloaded with 0xA5-pattern block -> exactly one mem_read pulse with mem_addr=0x000010, done at acceptance+4, fill_data=0xA5-pattern.
REQ-037 Bench SHALL drive wb+rd, wb_addr=0x7FFFFF, wb_data=all-ones, rd_addr=0x000000 -> mem_write pulse then mem_read pulse separated by 2 low cycles, done at acceptance+7, memory[0x7FFFFF]=all-ones.
REQ-038 Bench SHALL drive a command with both flags 0 -> no strobes, done at acceptance+2, fill_data unchanged.
REQ-039 Bench SHALL change req_valid and rd_addr during RD_WAIT -> req_ready=0, mem_addr unchanged, second command accepted only after return to IDLE.
REQ-040 Bench SHALL assert reset_n=0 during WB_WAIT -> strobes 0, no done, req_ready=1 after release, next rd-only command completes normally.
REQ-041 Bench SHALL run with MEM_LATENCY=1 back-to-back rd commands -> each read produces a distinct rising edge on mem_read, done spacing = 4 cycles.

Source files
------------

// File: rtl/mem_requester.sv
// mem_requester: sequences one cache command (optional block write-back,
// then optional block fill) against a fixed-latency main memory.
//   clk, reset_n           : clock, synchronous active-low reset
//   req_valid/req_ready    : command handshake (ready only while idle)
//   req_wb, wb_addr/data   : write-back request and its block
//   req_rd, rd_addr        : fill request and its block address
//   done, fill_data        : one-cycle completion pulse, captured fill block
//   mem_read/mem_write     : single-cycle strobes to main memory
//   mem_addr/mem_wdata     : address and write data held through each access
//   mem_rdata              : memory data_out, valid MEM_LATENCY cycles after strobe

package FUNCTIONS;
    // Ceiling log2 of a 64-bit value.
    function automatic int unsigned log(input longint unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            if ((64'd1 << i) < value) r = i + 1;
        end
        return r;
    endfunction
endpackage

module mem_requester #(
    parameter int unsigned     cache_block   = 512,
    parameter longint unsigned main_mem_size = 64'd512 * 64'd1024 * 64'd1024 * 64'd8,
    parameter int unsigned     MEM_LATENCY   = 2,
    localparam int unsigned    ADDR_W        = FUNCTIONS::log(main_mem_size / 64'(cache_block))
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_wb,
    input  logic                   req_rd,
    input  logic [ADDR_W-1:0]      wb_addr,
    input  logic [cache_block-1:0] wb_data,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic                   done,
    output logic [cache_block-1:0] fill_data,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [cache_block-1:0] mem_wdata,
    input  logic [cache_block-1:0] mem_rdata
);

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        WB_STB,
        WB_WAIT,
        RD_STB,
        RD_WAIT,
        DONE
    } state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                rd_pend;
    logic [ADDR_W-1:0]   rd_addr_q;

    // Command sequencer; strobes and done are set on the edge entering the
    // state in which they are visible, so they last exactly one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rd_pend   <= 1'b0;
            rd_addr_q <= '0;
            req_ready <= 1'b1;
            done      <= 1'b0;
            fill_data <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        rd_pend   <= req_rd;
                        rd_addr_q <= rd_addr;
                        if (req_wb) begin
                            state     <= WB_STB;
                            mem_write <= 1'b1;
                            mem_addr  <= wb_addr;
                            mem_wdata <= wb_data;
                        end else if (req_rd) begin
                            state    <= RD_STB;
                            mem_read <= 1'b1;
                            mem_addr <= rd_addr;
                        end else begin
                            // Empty command waits one extra cycle in DONE so
                            // done lands two cycles after acceptance.
                            state <= DONE;
                            cnt   <= 4'd1;
                        end
                    end
                end
                WB_STB: begin
                    state <= WB_WAIT;
                    cnt   <= CNT_LOAD;
                end
                WB_WAIT: begin
                    if (cnt == 4'd0) begin
                        if (rd_pend) begin
                            state    <= RD_STB;
                            mem_read <= 1'b1;
                            mem_addr <= rd_addr_q;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RD_STB: begin
                    state <= RD_WAIT;
                    cnt   <= CNT_LOAD;
                end
                RD_WAIT: begin
                    if (cnt == 4'd0) begin
                        fill_data <= mem_rdata;
                        state     <= DONE;
                        done      <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (cnt == 4'd0) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        cnt  <= cnt - 4'd1;
                        done <= (cnt == 4'd1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
